// File: rtl/noc_output_port.sv
// Transmit side of a NoC link: 2-entry flit FIFO, credit-based launch into the
// downstream input buffer, and head/body/tail framing check. Optional parity: NOC_LINK_PARITY_EN.
module noc_output_port #(
   parameter int unsigned FLIT_W    = 16,
   parameter int unsigned BUF_DEPTH = 8,
   parameter int unsigned CNT_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLIT_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic              link_write_o,
   output logic [FLIT_W-1:0] link_data_o,
   output logic              link_parity_o,
   input  logic              credit_i,
   output logic [CNT_W-1:0]  credits_o,
   output logic              busy_o,
   output logic              err_o
);

   typedef enum logic {IDLE, PKT} state_t;

   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(BUF_DEPTH);

   state_t            state, state_nxt;
   logic [FLIT_W-1:0] fifo_mem [2];
   logic              rd_ptr, wr_ptr;
   logic [1:0]        fifo_cnt;
   logic              fifo_full, fifo_empty;
   logic              push, pop;
   logic [FLIT_W-1:0] head_flit;
   logic [1:0]        head_type;
   logic [CNT_W-1:0]  credits;
   logic              proto_err, credit_ovf;

   assign fifo_full  = (fifo_cnt == 2'd2);
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign tx_ready_o = !fifo_full;
   assign push       = tx_valid_i && !fifo_full;
   assign pop        = !fifo_empty && (credits != '0);
   assign head_flit  = fifo_mem[rd_ptr];
   assign head_type  = head_flit[FLIT_W-1 -: 2];
   assign credit_ovf = credit_i && !pop && (credits == CRED_MAX);
   assign credits_o  = credits;
   assign busy_o     = (state == PKT);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= tx_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) wr_ptr <= !wr_ptr;
         if (pop)  rd_ptr <= !rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // A credit arriving at full count has nowhere to go: saturate and flag it.
   always_ff @(posedge clk) begin
      if (reset) begin
         credits <= CRED_MAX;
      end else if (pop && !credit_i) begin
         credits <= credits - 1'b1;
      end else if (!pop && credit_i && (credits != CRED_MAX)) begin
         credits <= credits + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      proto_err = 1'b0;
      if (pop) begin
         case (state)
            IDLE: begin
               if (head_type == 2'b10)      state_nxt = PKT;
               else if (head_type != 2'b11) proto_err = 1'b1;
            end
            PKT: begin
               if (head_type == 2'b01)      state_nxt = IDLE;
               else if (head_type != 2'b00) proto_err = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         link_write_o <= 1'b0;
         link_data_o  <= '0;
      end else begin
         link_write_o <= pop;
         if (pop) link_data_o <= head_flit;
      end
   end

`ifdef NOC_LINK_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (reset)    parity_q <= 1'b0;
      else if (pop) parity_q <= ^head_flit;
   end

   assign link_parity_o = parity_q;
`else
   assign link_parity_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)                        err_o <= 1'b0;
      else if (proto_err || credit_ovf) err_o <= 1'b1;
   end

endmodule
